// File: rtl/rr_rsp_router.sv
// rr_rsp_router
//   Response-path companion to the round-robin request arbiter tree. Each
//   granted request's source index is pushed into an in-order tracking FIFO;
//   each response from the shared in-order target is steered to the source
//   at the FIFO head and the entry is popped when that source accepts it.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   flush_i             synchronous clear of pointers/occupancy
//   alloc_valid_i       granted request this cycle (arbiter req_o & gnt_i)
//   alloc_idx_i         source index of the granted request
//   alloc_ready_o       tracker has a free slot (gate the arbiter grant)
//   rsp_valid_i/_ready_o/_data_i   shared response port
//   rsp_valid_o/_ready_i/_data_o   per-source response ports
//   outstanding_o       current tracker occupancy
//   err_o               (only with RR_RSP_ROUTER_ERR_EN) sticky protocol error
//
// Build option
//   RR_RSP_ROUTER_ERR_EN: responses arriving with nothing outstanding are
//   accepted and dropped, and they (or a push while full) set err_o.
//   Without it such responses stall and a push while full is ignored.
module rr_rsp_router #(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned Depth     = 4,
  localparam int unsigned IdxW     = (NumOut > 1) ? $clog2(NumOut) : 1,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  input  logic [IdxW-1:0]   alloc_idx_i,
  output logic              alloc_ready_o,
  input  logic              rsp_valid_i,
  output logic              rsp_ready_o,
  input  DataType           rsp_data_i,
  output logic [NumOut-1:0] rsp_valid_o,
  input  logic [NumOut-1:0] rsp_ready_i,
  output DataType           rsp_data_o [NumOut],
  output logic [CntW-1:0]   outstanding_o
`ifdef RR_RSP_ROUTER_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int unsigned     PtrW    = $clog2(Depth);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
`ifdef RR_RSP_ROUTER_ERR_EN
  localparam logic EmptyReady = 1'b1;
`else
  localparam logic EmptyReady = 1'b0;
`endif

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [IdxW-1:0] head_idx;
  logic            empty, full, push, pop;

  assign empty         = (count_q == '0);
  assign full          = (count_q == CntFull);
  // Depends on registered occupancy only, so no path from the response side.
  assign alloc_ready_o = ~full;
  assign push          = alloc_valid_i & ~full;
  assign pop           = rsp_valid_i & rsp_ready_o & ~empty;
  assign outstanding_o = count_q;

  if (NumOut > 1) begin : g_idx_store
    logic [IdxW-1:0] idx_mem [Depth];

    always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
        idx_mem[wr_ptr_q] <= alloc_idx_i;
      end
    end

    assign head_idx = idx_mem[rd_ptr_q];
  end else begin : g_no_idx_store
    assign head_idx = '0;
  end

  // Head is only read once count is non-zero, which rules out same-cycle bypass.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = EmptyReady;
    if (!empty) begin
      rsp_valid_o[head_idx] = rsp_valid_i;
      rsp_ready_o           = rsp_ready_i[head_idx];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumOut; i++) begin
      rsp_data_o[i] = rsp_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

`ifdef RR_RSP_ROUTER_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (flush_i) begin
      err_o <= 1'b0;
    end else if ((rsp_valid_i && empty) || (alloc_valid_i && full)) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule
